// File: rtl/control_ram_arbiter.sv
// Control RAM write arbiter: toggle-requested command writes always win over a background full-frame clear.
// The clear engine is present only when FB_CLEAR_ENGINE_EN is defined; otherwise only the command path exists.
`timescale 1ns/1ps

package params;
  localparam int BYTES_PER_PIXEL = 2;
  localparam int PIXEL_HEIGHT    = 32;
  localparam int PIXEL_WIDTH     = 64;
endpackage

package calc_pkg;
  function automatic int num_row_address_bits(input int height);
    return (height > 1) ? $clog2(height) : 1;
  endfunction

  function automatic int num_column_address_bits(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  function automatic int num_pixelcolorselect_bits(input int bytes_per_pixel);
    return (bytes_per_pixel > 1) ? $clog2(bytes_per_pixel) : 1;
  endfunction
endpackage

module control_ram_arbiter #(
  parameter int BYTES_PER_PIXEL = params::BYTES_PER_PIXEL,
  parameter int PIXEL_HEIGHT    = params::PIXEL_HEIGHT,
  parameter int PIXEL_WIDTH     = params::PIXEL_WIDTH,
  localparam int RB = calc_pkg::num_row_address_bits(PIXEL_HEIGHT),
  localparam int CB = calc_pkg::num_column_address_bits(PIXEL_WIDTH),
  localparam int PB = calc_pkg::num_pixelcolorselect_bits(BYTES_PER_PIXEL)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RB-1:0] cmd_row,
  input  logic [CB-1:0] cmd_column,
  input  logic [PB-1:0] cmd_pixel,
  input  logic [7:0]    cmd_data,
  input  logic          cmd_write_enable,
  input  logic          cmd_access_start,
  input  logic          clear_req,
  input  logic [7:0]    clear_value,
  output logic [RB-1:0] ram_row,
  output logic [CB-1:0] ram_column,
  output logic [PB-1:0] ram_pixel,
  output logic [7:0]    ram_data,
  output logic          ram_write_enable,
  output logic          clear_busy,
  output logic          clear_done
);

  logic prev_start;
  logic cmd_req;

  // Loading the live level in every cycle, reset included, means no request is seen right after reset.
  always_ff @(posedge clk) begin
    prev_start <= cmd_access_start;
  end

  assign cmd_req = (cmd_access_start != prev_start) && cmd_write_enable;

`ifdef FB_CLEAR_ENGINE_EN
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t        state;
  logic [RB-1:0] clr_row;
  logic [CB-1:0] clr_column;
  logic [PB-1:0] clr_pixel;
  logic [7:0]    clr_value;
  logic          last_row;
  logic          last_column;
  logic          last_pixel;

  assign last_row    = (clr_row    == RB'(PIXEL_HEIGHT - 1));
  assign last_column = (clr_column == CB'(PIXEL_WIDTH - 1));
  assign last_pixel  = (clr_pixel  == PB'(BYTES_PER_PIXEL - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      clr_row          <= '0;
      clr_column       <= '0;
      clr_pixel        <= '0;
      clr_value        <= '0;
      ram_row          <= '0;
      ram_column       <= '0;
      ram_pixel        <= '0;
      ram_data         <= '0;
      ram_write_enable <= 1'b0;
      clear_busy       <= 1'b0;
      clear_done       <= 1'b0;
    end else begin
      ram_write_enable <= 1'b0;
      // Status flags trail the state by one cycle, so clear_done lands one cycle after the last write.
      clear_busy       <= (state != IDLE);
      clear_done       <= (state == DONE);

      if (cmd_req) begin
        ram_row          <= cmd_row;
        ram_column       <= cmd_column;
        ram_pixel        <= cmd_pixel;
        ram_data         <= cmd_data;
        ram_write_enable <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (clear_req) begin
            state      <= CLEAR;
            clr_value  <= clear_value;
            clr_row    <= '0;
            clr_column <= '0;
            clr_pixel  <= '0;
          end
        end
        CLEAR: begin
          // A command write owns this cycle; the counters hold so no location is skipped.
          if (!cmd_req) begin
            ram_row          <= clr_row;
            ram_column       <= clr_column;
            ram_pixel        <= clr_pixel;
            ram_data         <= clr_value;
            ram_write_enable <= 1'b1;
            if (last_pixel) begin
              clr_pixel <= '0;
              if (last_column) begin
                clr_column <= '0;
                if (last_row) begin
                  clr_row <= '0;
                  state   <= DONE;
                end else begin
                  clr_row <= clr_row + 1'b1;
                end
              end else begin
                clr_column <= clr_column + 1'b1;
              end
            end else begin
              clr_pixel <= clr_pixel + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  logic unused_clear_inputs;

  always_ff @(posedge clk) begin
    if (reset) begin
      ram_row          <= '0;
      ram_column       <= '0;
      ram_pixel        <= '0;
      ram_data         <= '0;
      ram_write_enable <= 1'b0;
    end else begin
      ram_write_enable <= cmd_req;
      if (cmd_req) begin
        ram_row    <= cmd_row;
        ram_column <= cmd_column;
        ram_pixel  <= cmd_pixel;
        ram_data   <= cmd_data;
      end
    end
  end

  assign clear_busy          = 1'b0;
  assign clear_done          = 1'b0;
  assign unused_clear_inputs = ^{clear_req, clear_value};
`endif

endmodule
